// File: rtl/otp_digits_if.sv
// Handshake/readout bundle for the serial-to-decimal OTP digit engine.
// master drives the bit stream and digit select; slave is the engine.
interface otp_digits_if #(
    parameter int DIGITS = 6,
    parameter int SEL_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1
);
    logic             start;
    logic             bit_valid;
    logic             bit_in;
    logic             hex_mode;
    logic             scan_en;
    logic [SEL_W-1:0] sel;
    logic             busy;
    logic             ready;
    logic [3:0]       digit;
    logic [SEL_W-1:0] digit_idx;

    modport master (
        output start, bit_valid, bit_in, hex_mode, scan_en, sel,
        input  busy, ready, digit, digit_idx
    );

    modport slave (
        input  start, bit_valid, bit_in, hex_mode, scan_en, sel,
        output busy, ready, digit, digit_idx
    );
endinterface

// File: rtl/otp_digits.sv
// Serial MSB-first word -> DIGITS decimal (double-dabble, mod 10^DIGITS) or hex
// nibbles, double-buffered display with manual or scanned digit readout.
module otp_digits_cell (
    input  logic [3:0] d,
    output logic [3:0] c
);
    assign c = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module otp_digits #(
    parameter int DIGITS   = 6,
    parameter int IN_BITS  = 31,
    parameter int SCAN_DIV = 1024,
    parameter int SEL_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic        clk,
    input  logic        rst,
    otp_digits_if.slave bus
);
    localparam int ACC_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(IN_BITS + 1);
    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int NSLOT = 1 << SEL_W;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(IN_BITS - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(DIGITS - 1);

    if (DIGITS < 1 || DIGITS > 10) begin : g_bad_digits
        $error("otp_digits: DIGITS must be 1..10");
    end
    if (SCAN_DIV < 2) begin : g_bad_scan
        $error("otp_digits: SCAN_DIV must be >= 2");
    end

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t                  state;
    logic [DIGITS-1:0][3:0]  acc;
    logic [DIGITS-1:0][3:0]  corr;
    logic [DIGITS-1:0][3:0]  disp;
    logic [ACC_W-1:0]        acc_flat;
    logic [ACC_W-1:0]        corr_flat;
    logic [ACC_W-1:0]        shift_next;
    logic [CNT_W-1:0]        bit_cnt;
    logic                    hex_q;
    logic                    busy_q;
    logic                    ready_q;

    // Per-digit add-3 correction ahead of the shift.
    for (genvar g = 0; g < DIGITS; g++) begin : g_cell
        otp_digits_cell u_cell (
            .d (acc[g]),
            .c (corr[g])
        );
    end

    assign acc_flat   = acc;
    assign corr_flat  = corr;
    assign shift_next = hex_q ? {acc_flat[ACC_W-2:0], bus.bit_in}
                              : {corr_flat[ACC_W-2:0], bus.bit_in};

    // Load FSM; start takes priority over any bit offered in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            disp    <= '0;
            bit_cnt <= '0;
            hex_q   <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else if (bus.start) begin
            state   <= LOAD;
            acc     <= '0;
            bit_cnt <= '0;
            hex_q   <= bus.hex_mode;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
        end else if (state == LOAD && bus.bit_valid) begin
            acc <= shift_next;
            if (bit_cnt == LAST_BIT) begin
                disp    <= shift_next;
                bit_cnt <= '0;
                state   <= DONE;
                busy_q  <= 1'b0;
                ready_q <= 1'b1;
            end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.busy  = busy_q;
    assign bus.ready = ready_q;

    // Readout: out-of-range indices map to the blank code.
    logic [3:0] slot [NSLOT];
    for (genvar g = 0; g < NSLOT; g++) begin : g_slot
        if (g < DIGITS) begin : g_live
            assign slot[g] = disp[g];
        end else begin : g_blank
            assign slot[g] = 4'hF;
        end
    end

    logic [PRE_W-1:0] pre;
    logic [PRE_W-1:0] pre_next;
    logic             scan_q;
    logic [SEL_W-1:0] idx_q;
    logic [SEL_W-1:0] idx_next;
    logic [3:0]       digit_q;

    // First scanning cycle forces index 0 so it gets a full SCAN_DIV interval.
    always_comb begin
        idx_next = idx_q;
        pre_next = pre;
        if (!bus.scan_en) begin
            idx_next = bus.sel;
            pre_next = '0;
        end else if (!scan_q) begin
            idx_next = '0;
            pre_next = '0;
        end else if (pre == PRE_LAST) begin
            pre_next = '0;
            idx_next = (idx_q == LAST_IDX) ? '0 : idx_q + SEL_W'(1);
        end else begin
            pre_next = pre + PRE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre     <= '0;
            scan_q  <= 1'b0;
            idx_q   <= '0;
            digit_q <= 4'h0;
        end else begin
            pre     <= pre_next;
            scan_q  <= bus.scan_en;
            idx_q   <= idx_next;
            digit_q <= slot[idx_next];
        end
    end

    assign bus.digit     = digit_q;
    assign bus.digit_idx = idx_q;
endmodule

// File: doc/otp_digits.md
# otp_digits

Parametrised serial-to-decimal digit engine for the OTP datapath. It accepts the truncated HOTP value as an MSB-first bit stream, one bit per accepted cycle, and reduces it modulo 10^DIGITS with shift-and-add-3 (double-dabble) arithmetic. The result is held in a double-buffered display register. Each digit is readable by index, or by a built-in scan counter that drives multiplexed seven-segment displays. A hex mode passes the raw low nibbles through instead, for debug.

## Interface
Parameters:
- `DIGITS`, 6: number of output digits, 1..10.
- `IN_BITS`, 31: bits per input word.
- `SCAN_DIV`, 1024: cycles each digit is shown in scan mode, ≥ 2.
- `SEL_W`, derived: $clog2(DIGITS), minimum 1.

Ports:
- `clk` in 1: clock. Single clock domain; all state updates on the rising edge.
- `rst` in 1: reset. Synchronous, active-high.
- `start` in 1: one-cycle pulse that clears the accumulator and opens a new word.
- `bit_valid` in 1: `bit_in` is valid this cycle.
- `bit_in` in 1: serial data, MSB first.
- `hex_mode` in 1: 0 selects decimal, 1 selects hex nibbles. Sampled on `start`.
- `scan_en` in 1: 1 makes the digit index auto-cycle; 0 makes it follow `sel`.
- `sel` in `SEL_W`: digit index for manual readout; 0 is the least significant digit.
- `busy` out 1: word load in progress.
- `ready` out 1: display register holds a completed word.
- `digit` out 4: selected digit value (BCD, or hex nibble in hex mode).
- `digit_idx` out `SEL_W`: index currently shown on `digit`.

## Operation
State machine: IDLE, LOAD, DONE.
- Reset enters IDLE.
- `start` in any state enters LOAD. It also:
  - clears the accumulator and the bit counter;
  - latches `hex_mode`;
  - deasserts `ready`.
- LOAD, on a cycle with `bit_valid`:
  - shifts one bit into the accumulator;
  - increments the bit counter.
- When the `IN_BITS`-th bit is accepted:
  - the accumulator is copied to the display register on the same edge;
  - the machine enters DONE.
- DONE returns to LOAD only on `start`. There is no path back to IDLE except reset.
- `bit_valid` in IDLE or DONE is ignored. Gaps in `bit_valid` during LOAD stall the load; they are not errors.
- `start` together with `bit_valid` in the same cycle: `start` wins and that bit is discarded.

Decimal accumulator (`DIGITS` x 4 bits), per accepted bit:
- Each digit is corrected first: if d ≥ 5 then d + 3.
- The corrected digits then shift left by one bit as a whole. Bit 3 of each corrected digit carries into the next digit up. `bit_in` enters bit 0 of digit 0.
- The carry out of the top digit is dropped. This yields the value mod 10^DIGITS exactly, and every digit stays within 0..9.

Hex accumulator:
- Plain 4·DIGITS-bit left shift with `bit_in` entering at bit 0. Bits shifted out the top are lost.

Readout:
- The display register changes only when a load completes. A new load never disturbs the digits currently shown.
- `scan_en` = 0: `digit_idx` = `sel`. If `sel` ≥ `DIGITS`, `digit` = 4'hF (blank code).
- `scan_en` = 1:
  - a prescaler counts 0..SCAN_DIV-1;
  - on wrap, `digit_idx` increments, and DIGITS-1 wraps to 0;
  - `sel` is ignored.
- Deasserting `scan_en` resets the prescaler and `digit_idx` follows `sel` again. Reasserting it starts scanning from index 0 with a full SCAN_DIV interval.

## Timing
- All outputs are registered.
- Reset values: `busy` 0, `ready` 0, `digit` 0, `digit_idx` 0. The display register, accumulator, counters and prescaler are also 0.
- `busy` rises the cycle after `start`. It falls, and `ready` rises, the cycle after the last bit is accepted.
- Minimum load time: `IN_BITS` cycles of back-to-back `bit_valid`.
- Readout latency: one cycle from a `sel` change or display update to `digit` / `digit_idx`.
- Scan: each index is held exactly `SCAN_DIV` cycles.
- `rst` mid-load aborts the load. Everything returns to reset values, and the previous display contents are lost.

## Test plan
- Decimal load, DIGITS=6: `start`, then 31 bits of 0x4C93CF18 (RFC 4226 count 0) -> `ready` the cycle after the 31st bit; `sel` 5..0 reads 7,5,5,2,2,4.
- Same word with DIGITS=8 -> digits 8,4,7,5,5,2,2,4. With `hex_mode`=1 and DIGITS=6 -> `sel` 5..0 reads 9,3,C,F,1,8.
- Random `bit_valid` gaps while loading 0x41397EEA -> 287082. While it loads, `digit` keeps showing the previous 755224 with `ready` low.
- Second `start` after 10 bits of a load -> load restarts. 31 fresh bits give the correct result, with no residue from the aborted word.
- `scan_en`=1 with SCAN_DIV=4, DIGITS=6 -> `digit_idx` steps 0,1,2,3,4,5,0 every 4 cycles. `sel`=6 with `scan_en`=0 -> `digit`=F.
- `rst` asserted mid-load and in DONE -> next cycle `busy`=0, `ready`=0, `digit`=0; `bit_valid` pulses are then ignored until `start`.
